// File: rtl/boreal_ledger_chain_if.sv
// Ledger bus: event write handshake, audit read port and chain status.
// Latency: none (wires only).
// Backpressure: the writer holds wr_valid until the ledger raises wr_ready.
// Ports (modport slave = ledger side, master = writer/auditor side):
//   wr_valid/wr_ready/event_in/cycle_in   event offer handshake
//   rd_req/rd_addr -> rd_valid/rd_data/rd_err   one-cycle slot readback
//   idx/head_hash/full/busy   chain status
interface boreal_ledger_chain_if #(
    parameter int AW      = 10,
    parameter int EVT_W   = 160,
    parameter int ENTRY_W = 64 + 32 + EVT_W
);
    logic               wr_valid;
    logic               wr_ready;
    logic [EVT_W-1:0]   event_in;
    logic [31:0]        cycle_in;
    logic               rd_req;
    logic [AW-1:0]      rd_addr;
    logic               rd_valid;
    logic [ENTRY_W-1:0] rd_data;
    logic               rd_err;
    logic [31:0]        idx;
    logic [63:0]        head_hash;
    logic               full;
    logic               busy;

    modport master (
        output wr_valid, event_in, cycle_in, rd_req, rd_addr,
        input  wr_ready, rd_valid, rd_data, rd_err, idx, head_hash, full, busy
    );

    modport slave (
        input  wr_valid, event_in, cycle_in, rd_req, rd_addr,
        output wr_ready, rd_valid, rd_data, rd_err, idx, head_hash, full, busy
    );
endinterface

// File: rtl/boreal_ledger_chain.sv
// Hash-chained event ledger: FNV-1a-64 over {head_hash, stamp, event}, committed to on-chip RAM.
// Latency: handshake at T, hash T+1..T+NB, commit T+NB+1, results visible T+NB+2; reads R -> R+1.
// Backpressure: wr_ready low while hashing/committing; with WRAP=0 it stays low once full until rst.
// Ports: clk, rst (async active-high), bus (boreal_ledger_chain_if.slave).
// Optional macro BOREAL_LEDGER_STAMP_EN: stamp = cycle_in at the handshake, else stamp = 0.
module boreal_ledger_chain #(
    parameter int AW    = 10,
    parameter int EVT_W = 160,
    parameter int BPC   = 4,
    parameter int WRAP  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    boreal_ledger_chain_if.slave   bus
);
    localparam int ENTRY_W = 64 + 32 + EVT_W;
    localparam int DEPTH   = 1 << AW;
    localparam int NB      = ENTRY_W / (8 * BPC);
    localparam int CW      = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [63:0] FNV_OFFSET = 64'hCBF29CE484222325;
    localparam logic [63:0] FNV_PRIME  = 64'h00000100000001B3;

    typedef enum logic [1:0] {IDLE, HASH, COMMIT} state_t;

    state_t             state;
    logic [ENTRY_W-1:0] entry_q;
    logic [63:0]        h_q;
    logic [63:0]        h_next;
    logic [CW-1:0]      beat;
    logic [AW-1:0]      wptr;
    logic               full_q;
    logic [31:0]        idx_q;
    logic [63:0]        head_q;
    logic               wr_ready_q;
    logic               busy_q;
    logic [31:0]        stamp;

    logic               rd_valid_q;
    logic [ENTRY_W-1:0] rd_data_q;
    logic               rd_err_q;

    // No reset on the array: stale slots are hidden by rd_err until written.
    logic [ENTRY_W-1:0] mem [DEPTH];

`ifdef BOREAL_LEDGER_STAMP_EN
    assign stamp = bus.cycle_in;
`else
    assign stamp = 32'h0;
`endif

    // Advance the running hash over this beat's BPC bytes, lowest byte first.
    always_comb begin
        h_next = h_q;
        for (int i = 0; i < BPC; i++) begin
            h_next = (h_next ^ {56'h0, entry_q[(int'(beat) * BPC + i) * 8 +: 8]}) * FNV_PRIME;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            entry_q    <= '0;
            h_q        <= '0;
            beat       <= '0;
            wptr       <= '0;
            full_q     <= 1'b0;
            idx_q      <= '0;
            head_q     <= FNV_OFFSET;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wr_valid && wr_ready_q) begin
                        entry_q    <= {head_q, stamp, bus.event_in};
                        h_q        <= head_q;
                        beat       <= '0;
                        wr_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= HASH;
                    end else begin
                        wr_ready_q <= !(full_q && (WRAP == 0));
                    end
                end
                HASH: begin
                    h_q <= h_next;
                    if (beat == CW'(NB - 1)) begin
                        state <= COMMIT;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                COMMIT: begin
                    head_q <= h_q;
                    idx_q  <= idx_q + 32'd1;
                    wptr   <= wptr + 1'b1;
                    if (wptr == '1) begin
                        full_q <= 1'b1;
                    end
                    // Decide readiness from the post-commit fill state so a
                    // ledger that just filled never re-opens for one cycle.
                    wr_ready_q <= !((full_q || (wptr == '1)) && (WRAP == 0));
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == COMMIT) begin
            mem[wptr] <= entry_q;
        end
    end

    // Read-first: rd_err and data use pre-commit wptr/full and old RAM contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_req;
            if (bus.rd_req) begin
                if (full_q || (bus.rd_addr < wptr)) begin
                    rd_data_q <= mem[bus.rd_addr];
                    rd_err_q  <= 1'b0;
                end else begin
                    rd_data_q <= '0;
                    rd_err_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.wr_ready  = wr_ready_q;
    assign bus.busy      = busy_q;
    assign bus.idx       = idx_q;
    assign bus.head_hash = head_q;
    assign bus.full      = full_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_err    = rd_err_q;
endmodule

// File: tb/tb_boreal_ledger_chain.sv
// Directed bench: three ledgers (default, AW=2 stop-when-full, AW=2 ring) share one stimulus.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: offers wait (bounded) for wr_ready of the default-parameter ledger.
module tb_boreal_ledger_chain;
    localparam int EVT_W   = 160;
    localparam int ENTRY_W = 256;
    localparam int NB      = 8;
    localparam logic [63:0] OFFSET = 64'hCBF29CE484222325;
    localparam logic [63:0] PRIME  = 64'h00000100000001B3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    boreal_ledger_chain_if #(.AW(10), .EVT_W(EVT_W)) ifa ();
    boreal_ledger_chain_if #(.AW(2),  .EVT_W(EVT_W)) ifb ();
    boreal_ledger_chain_if #(.AW(2),  .EVT_W(EVT_W)) ifc ();

    boreal_ledger_chain #(.AW(10), .EVT_W(EVT_W), .BPC(4), .WRAP(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    boreal_ledger_chain #(.AW(2),  .EVT_W(EVT_W), .BPC(4), .WRAP(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    boreal_ledger_chain #(.AW(2),  .EVT_W(EVT_W), .BPC(4), .WRAP(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    int checks = 0;
    int errors = 0;

    logic [63:0]        head_m;
    logic [ENTRY_W-1:0] ent_m [6];
    logic [EVT_W-1:0]   evts  [6];
    logic [31:0]        cycs  [6];
    logic [ENTRY_W-1:0] rb    [6];
    logic [ENTRY_W-1:0] e6;

    function automatic logic [63:0] fnv(input logic [63:0] h0, input logic [ENTRY_W-1:0] e);
        logic [63:0] h;
        h = h0;
        for (int k = 0; k < ENTRY_W / 8; k++) begin
            h = (h ^ {56'h0, e[8*k +: 8]}) * PRIME;
        end
        return h;
    endfunction

    function automatic logic [31:0] stamp_of(input logic [31:0] c);
`ifdef BOREAL_LEDGER_STAMP_EN
        return c;
`else
        return 32'h0 & c;
`endif
    endfunction

    task automatic chk(input string tag, input logic [ENTRY_W-1:0] obs, input logic [ENTRY_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic v, input logic [EVT_W-1:0] evt, input logic [31:0] cyc);
        ifa.wr_valid = v; ifa.event_in = evt; ifa.cycle_in = cyc;
        ifb.wr_valid = v; ifb.event_in = evt; ifb.cycle_in = cyc;
        ifc.wr_valid = v; ifc.event_in = evt; ifc.cycle_in = cyc;
    endtask

    task automatic drive_rd(input logic req, input logic [9:0] addr);
        ifa.rd_req = req; ifa.rd_addr = addr;
        ifb.rd_req = req; ifb.rd_addr = addr[1:0];
        ifc.rd_req = req; ifc.rd_addr = addr[1:0];
    endtask

    task automatic do_read(input logic [9:0] addr);
        drive_rd(1'b1, addr);
        tick();
        drive_rd(1'b0, 10'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ifa.wr_ready && n < 50) begin
            tick();
            n++;
        end
        chk("wr_ready_before_offer", ifa.wr_ready, 1);
    endtask

    // Offer one event, then run out the NB+1 busy cycles; optionally read
    // slot 1 in the commit cycle. Returns at T+NB+2.
    task automatic send(input logic [EVT_W-1:0] evt, input logic [31:0] cyc,
                        input bit rd1, input bit chk_busy);
        wait_ready();
        drive_wr(1'b1, evt, cyc);
        tick();
        drive_wr(1'b0, ~evt, ~cyc);
        for (int k = 1; k <= NB + 1; k++) begin
            if (chk_busy) chk($sformatf("wr_ready_low_T+%0d", k), ifa.wr_ready, 0);
            if (rd1 && k == NB + 1) drive_rd(1'b1, 10'd1);
            tick();
        end
        drive_rd(1'b0, 10'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive_wr(1'b0, '0, '0);
        drive_rd(1'b0, 10'd0);
        evts[0] = '0;                                                   cycs[0] = 32'd5;
        evts[1] = 160'hA1A2A3A4_A5A6A7A8_A9AAABAC_ADAEAFB0_B1B2B3B4;    cycs[1] = 32'h0000_0011;
        evts[2] = 160'h01234567_89ABCDEF_FEDCBA98_76543210_DEADBEEF;    cycs[2] = 32'h1234_5678;
        evts[3] = 160'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;    cycs[3] = 32'hFFFF_FFFF;
        evts[4] = 160'h00000000_00000000_00000000_00000000_00000001;    cycs[4] = 32'h0000_0100;
        evts[5] = 160'h80000000_00000000_00000000_00000000_00000000;    cycs[5] = 32'h8000_0000;
        repeat (3) tick();

        // Reset state
        chk("rst_wr_ready", ifa.wr_ready, 0);
        chk("rst_idx", ifa.idx, 0);
        chk("rst_head_hash", ifa.head_hash, OFFSET);
        chk("rst_full", ifa.full, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_rd_valid", ifa.rd_valid, 0);
        chk("rst_rd_data", ifa.rd_data, 0);
        rst = 1'b0;
        tick();

        head_m = OFFSET;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                chk("b_full_after4", ifb.full, 1);
                chk("b_stall_5th", ifb.wr_ready, 0);
            end
            ent_m[i] = {head_m, stamp_of(cycs[i]), evts[i]};
            send(evts[i], cycs[i], (i == 1) || (i == 5), i == 0);
            head_m = fnv(head_m, ent_m[i]);
            if (i == 0) begin
                chk("e0_wr_ready_T+10", ifa.wr_ready, 1);
                chk("e0_idx", ifa.idx, 1);
                chk("e0_head_hash", ifa.head_hash, head_m);
                chk("e0_busy", ifa.busy, 0);
                do_read(10'd0);
                chk("e0_rd_valid", ifa.rd_valid, 1);
                chk("e0_rd_err", ifa.rd_err, 0);
                chk("e0_prev_hash", ifa.rd_data[255:192], OFFSET);
                chk("e0_entry", ifa.rd_data, ent_m[0]);
            end
            if (i == 1) begin
                // Read of slot 1 in the cycle it is committed: pre-commit view.
                chk("a_rdcommit_valid", ifa.rd_valid, 1);
                chk("a_rdcommit_err", ifa.rd_err, 1);
                chk("a_rdcommit_data", ifa.rd_data, 0);
                do_read(10'd3);
                chk("a_addr3_valid", ifa.rd_valid, 1);
                chk("a_addr3_err", ifa.rd_err, 1);
                chk("a_addr3_data", ifa.rd_data, 0);
                tick();
                chk("a_rd_valid_drops", ifa.rd_valid, 0);
            end
            if (i == 5) begin
                chk("c_rdcommit_err", ifc.rd_err, 0);
                chk("c_rdcommit_old", ifc.rd_data, ent_m[1]);
            end
        end

        chk("a_idx6", ifa.idx, 6);
        chk("a_head6", ifa.head_hash, head_m);
        chk("b_idx4", ifb.idx, 4);
        chk("b_full", ifb.full, 1);
        chk("b_wr_ready_held", ifb.wr_ready, 0);
        chk("c_idx6", ifc.idx, 6);
        chk("c_full", ifc.full, 1);
        chk("c_head6", ifc.head_hash, head_m);

        for (int k = 0; k < 6; k++) begin
            do_read(10'(k));
            rb[k] = ifa.rd_data;
            chk($sformatf("a_slot%0d", k), rb[k], ent_m[k]);
        end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("chain_link%0d", k), fnv(rb[k][255:192], rb[k]), rb[k+1][255:192]);
        end
        chk("chain_head", fnv(rb[5][255:192], rb[5]), ifa.head_hash);

        for (int k = 0; k < 4; k++) begin
            do_read(10'(k));
            chk($sformatf("c_slot%0d_err", k), ifc.rd_err, 0);
            chk($sformatf("c_slot%0d", k), ifc.rd_data, ent_m[(k < 2) ? k + 4 : k]);
        end

        // Reset during HASH cycle 4 with a read in flight.
        wait_ready();
        drive_wr(1'b1, evts[2], 32'h0BAD_0BAD);
        tick();
        drive_wr(1'b0, '0, '0);
        repeat (2) tick();
        drive_rd(1'b1, 10'd0);
        tick();
        drive_rd(1'b0, 10'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_valid", ifa.rd_valid, 0);
        chk("mid_rst_idx", ifa.idx, 0);
        chk("mid_rst_head", ifa.head_hash, OFFSET);
        chk("mid_rst_busy", ifa.busy, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_idx_after", ifa.idx, 0);
        chk("b_full_cleared", ifb.full, 0);

        e6 = {OFFSET, stamp_of(32'hCAFE_0001), evts[1]};
        send(evts[1], 32'hCAFE_0001, 1'b0, 1'b0);
        chk("post_rst_idx", ifa.idx, 1);
        chk("post_rst_head", ifa.head_hash, fnv(OFFSET, e6));
        do_read(10'd0);
        chk("post_rst_slot0", ifa.rd_data, e6);
        chk("post_rst_stamp", ifa.rd_data[191:160], stamp_of(32'hCAFE_0001));
        do_read(10'd1);
        chk("post_rst_slot1_err", ifa.rd_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
